// File: rtl/mem_access_ctrl.sv
// Memory-stage load/store sequencer: alignment check, single-outstanding
// valid/ready bus request, response wait with pipeline stall, flush draining.
module mem_access_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                op_valid,
  input  logic                op_load,
  input  logic                op_store,
  input  logic [1:0]          op_size,
  input  logic [ADDR_W-1:0]   op_addr,
  input  logic [DATA_W-1:0]   op_wdata,
  input  logic [DATA_W/8-1:0] op_strb,
  input  logic                flush,
  output logic                stall,
  output logic                op_done,
  output logic [DATA_W-1:0]   ld_rdata,
  output logic [1:0]          ld_ea,
  output logic                exc_adel,
  output logic                exc_ades,
  output logic [ADDR_W-1:0]   badvaddr,
  output logic                req_valid,
  input  logic                req_ready,
  output logic [ADDR_W-1:0]   req_addr,
  output logic [DATA_W/8-1:0] req_wen,
  output logic [DATA_W-1:0]   req_wdata,
  input  logic                resp_valid,
  input  logic [DATA_W-1:0]   resp_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DRAIN,
    S_DONE,
    S_EXC
  } state_t;

  state_t state;
  logic   cancel;
  logic   is_load;
  logic   op_accept;
  logic   misaligned;

  assign op_accept  = (state == S_IDLE) && op_valid && (op_load || op_store) && !flush;
  assign misaligned = ((op_size == 2'd1) && op_addr[0]) ||
                      ((op_size == 2'd2) && (op_addr[1:0] != 2'b00));

  // Stall drops in DONE/EXC so the pipeline advances exactly once per access.
  assign stall = op_accept || (state == S_REQ) || (state == S_WAIT) || (state == S_DRAIN);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      cancel    <= 1'b0;
      is_load   <= 1'b0;
      op_done   <= 1'b0;
      ld_rdata  <= '0;
      ld_ea     <= 2'b00;
      exc_adel  <= 1'b0;
      exc_ades  <= 1'b0;
      badvaddr  <= '0;
      req_valid <= 1'b0;
      req_addr  <= '0;
      req_wen   <= '0;
      req_wdata <= '0;
    end else begin
      op_done  <= 1'b0;
      exc_adel <= 1'b0;
      exc_ades <= 1'b0;
      case (state)
        S_IDLE: begin
          if (op_accept) begin
            if (misaligned) begin
              state    <= S_EXC;
              badvaddr <= op_addr;
              exc_ades <= op_store;
              exc_adel <= !op_store;
            end else begin
              state     <= S_REQ;
              req_valid <= 1'b1;
              req_addr  <= {op_addr[ADDR_W-1:2], 2'b00};
              req_wen   <= op_store ? op_strb : '0;
              req_wdata <= op_wdata;
              ld_ea     <= op_addr[1:0];
              is_load   <= !op_store;
            end
          end
        end
        // A flush here cannot withdraw valid; remember it and drain later.
        S_REQ: begin
          if (flush) cancel <= 1'b1;
          if (req_ready) begin
            req_valid <= 1'b0;
            state     <= (cancel || flush) ? S_DRAIN : S_WAIT;
          end
        end
        S_WAIT: begin
          if (flush) begin
            if (resp_valid) begin
              state  <= S_IDLE;
              cancel <= 1'b0;
            end else begin
              state <= S_DRAIN;
            end
          end else if (resp_valid) begin
            if (is_load) ld_rdata <= resp_rdata;
            op_done <= 1'b1;
            state   <= S_DONE;
          end
        end
        S_DRAIN: begin
          if (resp_valid) begin
            state  <= S_IDLE;
            cancel <= 1'b0;
          end
        end
        S_DONE, S_EXC: begin
          state  <= S_IDLE;
          cancel <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl: loads, stores, address
// errors, flush in REQ/WAIT, and reset during an outstanding transaction.
module tb_mem_access_ctrl;

  logic        clk;
  logic        resetn;
  logic        op_valid;
  logic        op_load;
  logic        op_store;
  logic [1:0]  op_size;
  logic [31:0] op_addr;
  logic [31:0] op_wdata;
  logic [3:0]  op_strb;
  logic        flush;
  logic        stall;
  logic        op_done;
  logic [31:0] ld_rdata;
  logic [1:0]  ld_ea;
  logic        exc_adel;
  logic        exc_ades;
  logic [31:0] badvaddr;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [3:0]  req_wen;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  mem_access_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .resetn(resetn),
    .op_valid(op_valid), .op_load(op_load), .op_store(op_store),
    .op_size(op_size), .op_addr(op_addr), .op_wdata(op_wdata), .op_strb(op_strb),
    .flush(flush), .stall(stall), .op_done(op_done),
    .ld_rdata(ld_rdata), .ld_ea(ld_ea),
    .exc_adel(exc_adel), .exc_ades(exc_ades), .badvaddr(badvaddr),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wen(req_wen), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic ld, input logic st,
                               input logic [1:0] sz, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] strb);
    op_valid = v;
    op_load  = ld;
    op_store = st;
    op_size  = sz;
    op_addr  = addr;
    op_wdata = wdata;
    op_strb  = strb;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_stall"},     32'(stall),     32'h0);
    checkOutput({tag, "_op_done"},   32'(op_done),   32'h0);
    checkOutput({tag, "_ld_rdata"},  ld_rdata,       32'h0);
    checkOutput({tag, "_ld_ea"},     32'(ld_ea),     32'h0);
    checkOutput({tag, "_exc_adel"},  32'(exc_adel),  32'h0);
    checkOutput({tag, "_exc_ades"},  32'(exc_ades),  32'h0);
    checkOutput({tag, "_badvaddr"},  badvaddr,       32'h0);
    checkOutput({tag, "_req_valid"}, 32'(req_valid), 32'h0);
    checkOutput({tag, "_req_addr"},  req_addr,       32'h0);
    checkOutput({tag, "_req_wen"},   32'(req_wen),   32'h0);
    checkOutput({tag, "_req_wdata"}, req_wdata,      32'h0);
  endtask

  initial begin
    resetn = 1'b0; flush = 1'b0; req_ready = 1'b0;
    resp_valid = 1'b0; resp_rdata = 32'h0;
    applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 4'h0);
    tick();
    checkAllZero("reset");
    resetn = 1'b1;
    tick();

    // lw 0x1000, minimum latency
    req_ready = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 2'd2, 32'h0000_1000, 32'h0, 4'h0);
    checkOutput("lw_stall_c1", 32'(stall), 32'h1);
    tick();
    checkOutput("lw_req_valid", 32'(req_valid), 32'h1);
    checkOutput("lw_req_addr", req_addr, 32'h0000_1000);
    checkOutput("lw_req_wen", 32'(req_wen), 32'h0);
    checkOutput("lw_stall_c2", 32'(stall), 32'h1);
    tick();
    checkOutput("lw_req_drop", 32'(req_valid), 32'h0);
    checkOutput("lw_stall_c3", 32'(stall), 32'h1);
    resp_valid = 1'b1; resp_rdata = 32'hDEAD_BEEF;
    tick();
    resp_valid = 1'b0; req_ready = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 4'h0);
    checkOutput("lw_done", 32'(op_done), 32'h1);
    checkOutput("lw_rdata", ld_rdata, 32'hDEAD_BEEF);
    checkOutput("lw_ea", 32'(ld_ea), 32'h0);
    checkOutput("lw_stall_done", 32'(stall), 32'h0);
    tick();
    checkOutput("lw_done_clr", 32'(op_done), 32'h0);

    // sb 0x2003 with req_ready held off for 4 cycles
    applyStimulus(1'b1, 1'b0, 1'b1, 2'd0, 32'h0000_2003, 32'hAB00_0000, 4'b1000);
    tick();
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("sb_req_valid_%0d", i), 32'(req_valid), 32'h1);
      checkOutput($sformatf("sb_req_addr_%0d", i), req_addr, 32'h0000_2000);
      checkOutput($sformatf("sb_req_wen_%0d", i), 32'(req_wen), 32'h8);
      checkOutput($sformatf("sb_req_wdata_%0d", i), req_wdata, 32'hAB00_0000);
      checkOutput($sformatf("sb_stall_%0d", i), 32'(stall), 32'h1);
      if (i == 3) req_ready = 1'b1;
      tick();
    end
    req_ready = 1'b0;
    checkOutput("sb_req_drop", 32'(req_valid), 32'h0);
    checkOutput("sb_no_early_done", 32'(op_done), 32'h0);
    resp_valid = 1'b1; resp_rdata = 32'h5555_5555;
    tick();
    resp_valid = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 4'h0);
    checkOutput("sb_done", 32'(op_done), 32'h1);
    checkOutput("sb_rdata_kept", ld_rdata, 32'hDEAD_BEEF);
    checkOutput("sb_ea", 32'(ld_ea), 32'h3);
    tick();
    checkOutput("sb_done_clr", 32'(op_done), 32'h0);

    // lh 0x3001 -> AdEL
    applyStimulus(1'b1, 1'b1, 1'b0, 2'd1, 32'h0000_3001, 32'h0, 4'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 4'h0);
    checkOutput("lh_adel", 32'(exc_adel), 32'h1);
    checkOutput("lh_ades", 32'(exc_ades), 32'h0);
    checkOutput("lh_badvaddr", badvaddr, 32'h0000_3001);
    checkOutput("lh_no_req", 32'(req_valid), 32'h0);
    checkOutput("lh_stall", 32'(stall), 32'h0);
    tick();
    checkOutput("lh_adel_clr", 32'(exc_adel), 32'h0);

    // sw 0x3002 -> AdES
    applyStimulus(1'b1, 1'b0, 1'b1, 2'd2, 32'h0000_3002, 32'h1111_2222, 4'hF);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 4'h0);
    checkOutput("sw_ades", 32'(exc_ades), 32'h1);
    checkOutput("sw_adel", 32'(exc_adel), 32'h0);
    checkOutput("sw_badvaddr", badvaddr, 32'h0000_3002);
    checkOutput("sw_no_req", 32'(req_valid), 32'h0);
    tick();
    checkOutput("sw_ades_clr", 32'(exc_ades), 32'h0);

    // lw 0x5000, flush in WAIT, late response drained; next op waits for IDLE
    req_ready = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 2'd2, 32'h0000_5000, 32'h0, 4'h0);
    tick();
    tick();
    req_ready = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, 2'd2, 32'h0000_6000, 32'h0, 4'h0);
    checkOutput("fw_drain_stall1", 32'(stall), 32'h1);
    checkOutput("fw_no_done1", 32'(op_done), 32'h0);
    tick();
    resp_valid = 1'b1; resp_rdata = 32'h1234_5678;
    checkOutput("fw_drain_stall2", 32'(stall), 32'h1);
    checkOutput("fw_no_req", 32'(req_valid), 32'h0);
    tick();
    resp_valid = 1'b0;
    checkOutput("fw_no_done2", 32'(op_done), 32'h0);
    checkOutput("fw_rdata_kept", ld_rdata, 32'hDEAD_BEEF);
    checkOutput("fw_next_accept", 32'(stall), 32'h1);
    req_ready = 1'b1;
    tick();
    checkOutput("fw_next_addr", req_addr, 32'h0000_6000);
    tick();
    req_ready = 1'b0;
    resp_valid = 1'b1; resp_rdata = 32'hCAFE_F00D;
    tick();
    resp_valid = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 4'h0);
    checkOutput("fw_next_done", 32'(op_done), 32'h1);
    checkOutput("fw_next_rdata", ld_rdata, 32'hCAFE_F00D);
    tick();

    // lw 0x7000, flush in REQ while not ready; handshake still completes then drains
    applyStimulus(1'b1, 1'b1, 1'b0, 2'd2, 32'h0000_7000, 32'h0, 4'h0);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 4'h0);
    checkOutput("fr_valid_held", 32'(req_valid), 32'h1);
    checkOutput("fr_stall", 32'(stall), 32'h1);
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    checkOutput("fr_req_drop", 32'(req_valid), 32'h0);
    checkOutput("fr_drain_stall", 32'(stall), 32'h1);
    resp_valid = 1'b1; resp_rdata = 32'h9999_9999;
    tick();
    resp_valid = 1'b0;
    checkOutput("fr_no_done", 32'(op_done), 32'h0);
    checkOutput("fr_rdata_kept", ld_rdata, 32'hCAFE_F00D);
    checkOutput("fr_idle_stall", 32'(stall), 32'h0);

    // follow-up lw must go through WAIT normally (cancel cleared)
    req_ready = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 2'd2, 32'h0000_7004, 32'h0, 4'h0);
    tick();
    tick();
    req_ready = 1'b0;
    resp_valid = 1'b1; resp_rdata = 32'h1111_2222;
    tick();
    resp_valid = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 4'h0);
    checkOutput("fr_next_done", 32'(op_done), 32'h1);
    checkOutput("fr_next_rdata", ld_rdata, 32'h1111_2222);
    tick();

    // reset during WAIT, late response ignored, then lb 0x9002 completes
    req_ready = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 2'd2, 32'h0000_8000, 32'h0, 4'h0);
    tick();
    tick();
    req_ready = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 4'h0);
    resetn = 1'b0;
    #1;
    checkAllZero("midrst");
    tick();
    resetn = 1'b1;
    resp_valid = 1'b1; resp_rdata = 32'h7777_7777;
    tick();
    resp_valid = 1'b0;
    checkOutput("midrst_late_done", 32'(op_done), 32'h0);
    checkOutput("midrst_late_rdata", ld_rdata, 32'h0);
    req_ready = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 2'd0, 32'h0000_9002, 32'h0, 4'h0);
    tick();
    checkOutput("lb_req_addr", req_addr, 32'h0000_9000);
    tick();
    req_ready = 1'b0;
    resp_valid = 1'b1; resp_rdata = 32'h0BAD_F00D;
    tick();
    resp_valid = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 4'h0);
    checkOutput("lb_done", 32'(op_done), 32'h1);
    checkOutput("lb_rdata", ld_rdata, 32'h0BAD_F00D);
    checkOutput("lb_ea", 32'(ld_ea), 32'h2);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Memory-stage load/store sequencer for the MIPS pipeline. It sits between the memory-stage decode (lane-shifted store data and byte strobes from the write-back/store mux) and the single-port data bus.
- Checks alignment and raises AdEL/AdES. Issues one word-aligned request over a valid/ready handshake, waits for the response and stalls the pipeline meanwhile.
- Returns the raw read word plus the ea offset, which the load-lane extraction logic uses.
- Handles pipeline flush mid-transaction by draining the outstanding response.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; the strobe width is DATA_W/8 (4).

Ports:
- clk  in  1  clock
- resetn  in  1  reset, asynchronous, active-low
- op_valid  in  1  memory-stage instruction is valid
- op_load  in  1  instruction is a load
- op_store  in  1  instruction is a store; wins if op_load is also set
- op_size  in  2  access size: 0 byte, 1 half, 2 word, 3 partial (lwl/lwr/swl/swr, no alignment check)
- op_addr  in  32  effective address
- op_wdata  in  32  lane-shifted store data
- op_strb  in  4  byte strobes for the store
- flush  in  1  exception/ERET flush from WB
- stall  out  1  hold the memory stage and upstream stages
- op_done  out  1  one-cycle pulse: access completed
- ld_rdata  out  32  raw response word, latched
- ld_ea  out  2  op_addr[1:0] of the completed access
- exc_adel  out  1  load address error pulse
- exc_ades  out  1  store address error pulse
- badvaddr  out  32  faulting address
- req_valid  out  1  bus request valid
- req_ready  in  1  bus accepts the request
- req_addr  out  32  {op_addr[31:2],2'b00}
- req_wen  out  4  op_strb for stores, 4'b0000 for loads
- req_wdata  out  32  store data
- resp_valid  in  1  response/ack, arrives at least 1 cycle after the request handshake
- resp_rdata  in  32  read data, ignored for stores

Behaviour:
- States: IDLE, REQ, WAIT, DRAIN, DONE, EXC. All outputs are registered except stall.
- Reset (resetn=0, async): state IDLE; cancel flag 0; all outputs 0, including ld_rdata, badvaddr, req_*.
- op_accept = state==IDLE && op_valid && (op_load|op_store) && !flush.
- Misalignment: op_size 1 with addr[0]!=0, or op_size 2 with addr[1:0]!=0.
- IDLE, op_accept and misaligned:
  - Next state EXC. No bus request is issued.
  - badvaddr <= op_addr. exc_ades <= store, exc_adel <= load.
- IDLE, op_accept and aligned:
  - Next state REQ. req_valid <= 1.
  - req_addr, req_wen and req_wdata are latched. ld_ea <= op_addr[1:0].
- REQ: req_valid stays 1 and the payload is stable until req_ready. Valid is never withdrawn.
  - On req_ready: req_valid <= 0.
  - Next state is WAIT, or DRAIN if the cancel flag is set or flush is active that cycle.
- flush while in REQ: sets the cancel flag. The handshake still completes.
- WAIT:
  - resp_valid: ld_rdata <= resp_rdata (loads only), op_done <= 1, next state DONE.
  - flush without resp_valid: next state DRAIN.
  - flush with resp_valid in the same cycle: flush wins. Next state IDLE, no op_done, ld_rdata unchanged.
- DRAIN: wait for resp_valid, then go to IDLE. Response data is discarded, no op_done. The cancel flag clears on IDLE entry.
- DONE / EXC: one cycle only, then IDLE.
  - The op_done or exc_* pulse is visible in this cycle; it is cleared on exit.
  - op inputs are not sampled in these states, so the completing instruction is never re-accepted.
- stall = op_accept || state in {REQ, WAIT, DRAIN}.
  - stall=0 in DONE and EXC, so the pipeline advances exactly once per access.
  - The pipeline holds op_* stable while stall=1.
- Single outstanding transaction. Minimum load latency: accept cycle, REQ, WAIT (response), DONE, i.e. op_done 3 cycles after accept when req_ready=1 in REQ and resp_valid arrives 1 cycle later.
- Mid-operation reset: immediate return to IDLE. Any in-flight bus response afterwards is ignored (resp_valid is sampled only in WAIT/DRAIN).

Test Plan:
- lw at 0x1000, req_ready=1, resp one cycle later with 0xDEADBEEF -> req_addr=0x1000, req_wen=0; op_done pulses, ld_rdata=0xDEADBEEF, ld_ea=0; stall high for exactly 3 cycles.
- sb at 0x2003, op_strb=4'b1000, op_wdata=0xAB000000, req_ready delayed 4 cycles -> req_valid and payload held stable 4 cycles; req_addr=0x2000, req_wen=4'b1000; one op_done.
- lh at 0x3001 -> no req_valid; exc_adel=1 for 1 cycle, badvaddr=0x3001. sw at 0x3002 -> exc_ades=1, badvaddr=0x3002.
- lw accepted, flush in WAIT, resp arrives 2 cycles later with 0x12345678 -> no op_done; ld_rdata keeps its previous value; a new op_valid is stalled until IDLE.
- flush in REQ with req_ready=0, then req_ready=1 -> handshake completes, DRAIN, response swallowed, back to IDLE.
- resetn asserted during WAIT -> all outputs 0 asynchronously. A late resp_valid is ignored; the next lw completes normally.
